// File: rtl/rps_match_engine.sv
// Rock-paper-scissors match engine: collects two moves, resolves rounds,
// keeps score to WIN_SCORE. Optional forfeit timer via RPS_TIMEOUT_EN.
module rps_match_engine #(
    parameter int WIN_SCORE      = 3,
    parameter int SCORE_W        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         p1_move,
    input  logic               p1_valid,
    output logic               p1_ready,
    input  logic [1:0]         p2_move,
    input  logic               p2_valid,
    output logic               p2_ready,
    input  logic               new_match,
    output logic [1:0]         result,
    output logic               result_valid,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [7:0]         round_cnt,
    output logic               match_over,
    output logic [1:0]         match_winner,
    output logic               timeout_flag
);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_RESOLVE = 2'd1;
    localparam logic [1:0] S_OVER    = 2'd2;

    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] ONE = SCORE_W'(1);

    if (WIN_SCORE < 1 || WIN_SCORE > (2**SCORE_W) - 1 ||
        TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("rps_match_engine: parameter out of range");
    end

    logic [1:0]         r_state;
    logic               r_p1_lat;
    logic               r_p2_lat;
    logic [1:0]         r_p1_mv;
    logic [1:0]         r_p2_mv;
    logic [1:0]         r_result;
    logic               r_rv;
    logic [SCORE_W-1:0] r_p1_score;
    logic [SCORE_W-1:0] r_p2_score;
    logic [7:0]         r_round;
    logic [1:0]         r_winner;

    logic               w_p1_rdy;
    logic               w_p2_rdy;
    logic               w_p1_acc;
    logic               w_p2_acc;
    logic               w_both;
    logic               w_to;
    logic [1:0]         w_res;
    logic [1:0]         w_fm;
    logic [SCORE_W-1:0] w_p1_nxt;
    logic [SCORE_W-1:0] w_p2_nxt;

`ifdef RPS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_ONE  = TW'(1);

    logic [TW-1:0] r_tcnt;
    logic          r_to;
    logic          r_tflag;

    assign w_to         = r_to;
    assign timeout_flag = r_tflag;
`else
    assign w_to         = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    assign w_p1_rdy = (r_state == S_COLLECT) && !r_p1_lat;
    assign w_p2_rdy = (r_state == S_COLLECT) && !r_p2_lat;
    assign w_p1_acc = p1_valid && w_p1_rdy;
    assign w_p2_acc = p2_valid && w_p2_rdy;
    assign w_both   = (r_p1_lat || w_p1_acc) && (r_p2_lat || w_p2_acc);

    // Round outcome from the latched moves (forfeit: latched player wins)
    always_comb begin
        w_res = 2'b11;
        w_fm  = r_p1_lat ? r_p1_mv : r_p2_mv;
        if (w_to) begin
            if (w_fm == 2'b11)
                w_res = 2'b11;
            else
                w_res = r_p1_lat ? 2'b01 : 2'b10;
        end else if (r_p1_mv == 2'b11 || r_p2_mv == 2'b11) begin
            w_res = 2'b11;
        end else if (r_p1_mv == r_p2_mv) begin
            w_res = 2'b00;
        end else begin
            unique case (1'b1)
                (r_p1_mv == 2'b00 && r_p2_mv == 2'b10): w_res = 2'b01;
                (r_p1_mv == 2'b10 && r_p2_mv == 2'b01): w_res = 2'b01;
                (r_p1_mv == 2'b01 && r_p2_mv == 2'b00): w_res = 2'b01;
                default:                                w_res = 2'b10;
            endcase
        end
        w_p1_nxt = (w_res == 2'b01) ? r_p1_score + ONE : r_p1_score;
        w_p2_nxt = (w_res == 2'b10) ? r_p2_score + ONE : r_p2_score;
    end

    // Main FSM, move latches, scoring and restart handling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_COLLECT;
            r_p1_lat   <= 1'b0;
            r_p2_lat   <= 1'b0;
            r_p1_mv    <= 2'b00;
            r_p2_mv    <= 2'b00;
            r_result   <= 2'b00;
            r_rv       <= 1'b0;
            r_p1_score <= '0;
            r_p2_score <= '0;
            r_round    <= 8'd0;
            r_winner   <= 2'b00;
`ifdef RPS_TIMEOUT_EN
            r_tcnt     <= '0;
            r_to       <= 1'b0;
            r_tflag    <= 1'b0;
`endif
        end else begin
            r_rv <= 1'b0;
`ifdef RPS_TIMEOUT_EN
            r_tflag <= 1'b0;
`endif
            if (new_match) begin
                r_state    <= S_COLLECT;
                r_p1_lat   <= 1'b0;
                r_p2_lat   <= 1'b0;
                r_p1_mv    <= 2'b00;
                r_p2_mv    <= 2'b00;
                r_result   <= 2'b00;
                r_p1_score <= '0;
                r_p2_score <= '0;
                r_round    <= 8'd0;
                r_winner   <= 2'b00;
`ifdef RPS_TIMEOUT_EN
                r_tcnt     <= '0;
                r_to       <= 1'b0;
`endif
            end else begin
                unique case (r_state)
                    S_COLLECT: begin
                        if (w_p1_acc) begin
                            r_p1_lat <= 1'b1;
                            r_p1_mv  <= p1_move;
                        end
                        if (w_p2_acc) begin
                            r_p2_lat <= 1'b1;
                            r_p2_mv  <= p2_move;
                        end
                        if (w_both)
                            r_state <= S_RESOLVE;
`ifdef RPS_TIMEOUT_EN
                        if (w_both) begin
                            r_tcnt <= '0;
                        end else if (r_p1_lat ^ r_p2_lat) begin
                            if (r_tcnt == TO_LAST) begin
                                r_state <= S_RESOLVE;
                                r_to    <= 1'b1;
                                r_tcnt  <= '0;
                            end else begin
                                r_tcnt <= r_tcnt + TO_ONE;
                            end
                        end
`endif
                    end
                    S_RESOLVE: begin
                        r_result   <= w_res;
                        r_rv       <= 1'b1;
                        r_p1_score <= w_p1_nxt;
                        r_p2_score <= w_p2_nxt;
                        r_round    <= r_round + 8'd1;
                        r_p1_lat   <= 1'b0;
                        r_p2_lat   <= 1'b0;
                        r_p1_mv    <= 2'b00;
                        r_p2_mv    <= 2'b00;
`ifdef RPS_TIMEOUT_EN
                        r_tflag    <= r_to;
                        r_to       <= 1'b0;
`endif
                        if (w_p1_nxt == WIN) begin
                            r_state  <= S_OVER;
                            r_winner <= 2'b01;
                        end else if (w_p2_nxt == WIN) begin
                            r_state  <= S_OVER;
                            r_winner <= 2'b10;
                        end else begin
                            r_state <= S_COLLECT;
                        end
                    end
                    S_OVER: begin
                        r_state <= S_OVER;
                    end
                    default: begin
                        r_state <= S_COLLECT;
                    end
                endcase
            end
        end
    end

    assign p1_ready     = w_p1_rdy;
    assign p2_ready     = w_p2_rdy;
    assign result       = r_result;
    assign result_valid = r_rv;
    assign p1_score     = r_p1_score;
    assign p2_score     = r_p2_score;
    assign round_cnt    = r_round;
    assign match_over   = (r_state == S_OVER);
    assign match_winner = r_winner;

endmodule

// File: doc/rps_match_engine.md
RPS_MATCH_ENGINE -- requirements
Module: rps_match_engine

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 3: round wins needed to take the match (1..2^SCORE_W-1).
REQ-002 SHALL have parameter SCORE_W, default 4: width of each score counter.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255: forfeit window, used only with RPS_TIMEOUT_EN.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 p1_move  in  2  P1 move: 00 stone, 01 paper, 10 scissors, 11 invalid.
REQ-007 p1_valid  in  1  P1 move offer; accepted when p1_valid and p1_ready are both high.
REQ-008 p1_ready  out  1  high in COLLECT while no P1 move is latched.
REQ-009 p2_move, p2_valid, p2_ready  in/in/out  2/1/1  same as P1, for P2.
REQ-010 new_match  in  1  synchronous match restart strobe.
REQ-011 result  out  2  last round outcome: 00 tie, 01 P1 win, 10 P2 win, 11 invalid.
REQ-012 result_valid  out  1  one-cycle pulse when result updates.
REQ-013 p1_score, p2_score  out  SCORE_W  rounds won by each player.
REQ-014 round_cnt  out  8  rounds resolved this match.
REQ-015 match_over  out  1  high while in MATCH_OVER.
REQ-016 match_winner  out  2  00 none, 01 P1, 10 P2.
REQ-017 timeout_flag  out  1  high with result_valid when the round ended by forfeit.

Function
REQ-018 SHALL implement FSM states COLLECT, RESOLVE, MATCH_OVER.
REQ-019 COLLECT: each player's move SHALL latch independently; same-cycle offers from both SHALL both latch; offers with ready low SHALL be ignored.
REQ-020 At the edge where both moves are latched, the FSM SHALL enter RESOLVE.
REQ-021 RESOLVE lasts one cycle; on the following edge result, scores and round_cnt SHALL update, result_valid SHALL pulse, and both latches SHALL clear.
REQ-022 Latency: result_valid SHALL be high exactly 2 cycles after the edge that latched the second move.
REQ-023 Rules: stone beats scissors, scissors beats paper, paper beats stone; equal moves give 00 with no score change.
REQ-024 If either move is 11, result SHALL be 11, scores SHALL not change, round_cnt SHALL still increment.
REQ-025 round_cnt SHALL wrap 255 -> 0.
REQ-026 When a score reaches WIN_SCORE, the FSM SHALL go to MATCH_OVER on the same edge as the score update, with match_winner set; otherwise it SHALL return to COLLECT.
REQ-027 MATCH_OVER: both readys SHALL be low, and scores, result and match_winner SHALL hold until new_match.
REQ-028 new_match in any state SHALL clear scores, round_cnt, latches, result, match_winner and timeout counter, and SHALL enter COLLECT on the next edge.
REQ-029 new_match SHALL take priority: move offers in the same cycle SHALL be dropped.
REQ-030 No separate saturation logic is needed; WIN_SCORE bounds each score.

Reset
REQ-031 While rst is high, all outputs SHALL be 0 except p1_ready and p2_ready, which SHALL be 1; FSM=COLLECT; latches and counters cleared.
REQ-032 rst asserted mid-round SHALL discard latched moves, with no result_valid pulse.

Configuration
REQ-033 Macro RPS_TIMEOUT_EN defined: an internal counter SHALL run while exactly one move is latched.
REQ-034 When that counter reaches TIMEOUT_CYCLES, the FSM SHALL enter RESOLVE and the latched player SHALL win the round (result 01/10, timeout_flag=1, score +1).
REQ-035 In that case, a latched move of 11 SHALL still give result 11.
REQ-036 Under RPS_TIMEOUT_EN, the counter SHALL clear when the second move latches.
REQ-037 Macro RPS_TIMEOUT_EN undefined: no counter SHALL exist, the FSM SHALL wait indefinitely, and timeout_flag SHALL be tied 0.

Verification
REQ-038 P1=00 and P2=10 offered in the same cycle -> result 01 and p1_score 1 at +2 cycles, result_valid high for 1 cycle.
REQ-039 P1=01 at cycle 0, P2=00 at cycle 5 -> p1_ready low from cycle 1, result 01 at cycle 7; P2 offer at cycle 3 with p2_move=11 -> result 11, scores unchanged, round_cnt +1.
REQ-040 WIN_SCORE=3, P2 wins 3 rounds -> match_over=1, match_winner=10, readys low; further offers ignored; new_match -> all cleared next cycle.
REQ-041 Ties 10/10 three times -> result 00 each time, round_cnt 3, scores 0.
REQ-042 RPS_TIMEOUT_EN, TIMEOUT_CYCLES=8, only P1=00 offered -> after 8 cycles result 01, timeout_flag 1; without the macro, no result after 1000 cycles.
REQ-043 rst pulsed with P1 latched -> readys 1, no result_valid; new_match in the same cycle as both valids -> moves dropped, scores 0.
